// File: rtl/config_loader.sv
// Config chain loader: takes host words over valid/ready, clears the
// chain, then shifts exactly CONFIG_WIDTH bits MSB-first into it.
module config_loader #(
  parameter  int CONFIG_WIDTH = 1602,
  parameter  int WORD_WIDTH   = 8,
  localparam int BCW = $clog2(CONFIG_WIDTH + 1),
  localparam int WBW = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic                  busy,
  output logic                  done,
  output logic [BCW-1:0]        bit_count
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, SHIFT, DONE
  } state_t;

  localparam logic [BCW-1:0] CW_LAST = BCW'(CONFIG_WIDTH - 1);
  localparam logic [WBW-1:0] WB_LAST = WBW'(WORD_WIDTH - 1);

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] word_reg, word_reg_n;
  logic [WBW-1:0]        word_bit, word_bit_n;
  logic [BCW-1:0]        count, count_n;
  logic                  done_q, done_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      word_reg <= '0;
      word_bit <= '0;
      count    <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      word_reg <= word_reg_n;
      word_bit <= word_bit_n;
      count    <= count_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    word_reg_n = word_reg;
    word_bit_n = word_bit;
    count_n    = count;
    done_n     = done_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        count_n = '0;
        done_n  = 1'b0;
        state_n = LOAD;
      end
      LOAD: begin
        if (word_valid) begin
          word_reg_n = word_data;
          word_bit_n = '0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        word_reg_n = word_reg << 1;
        word_bit_n = word_bit + WBW'(1);
        count_n    = count + BCW'(1);
        // Chain full wins; leftover word bits are dropped.
        if (count == CW_LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (word_bit == WB_LAST) begin
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  assign word_ready = (state == LOAD);
  assign cfg_enable = (state == SHIFT);
  assign cfg_data   = (state == SHIFT) && word_reg[WORD_WIDTH-1];
  assign cfg_nreset = !(reset || state == CLEAR);
  assign busy       = (state == CLEAR) || (state == LOAD)
                   || (state == SHIFT);
  assign done       = done_q;
  assign bit_count  = count;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: default 1602x8 instance plus a
// small 5x4 instance, each with a behavioural shift register model.
module tb_config_loader;

  localparam int CW = 1602;

  logic        clock;
  logic        reset;
  logic        start, abort;
  logic [7:0]  word_data;
  logic        word_valid, word_ready;
  logic        cfg_data, cfg_enable, cfg_nreset;
  logic        busy, done;
  logic [10:0] bit_count;

  logic        s_start, s_abort;
  logic [3:0]  s_word_data;
  logic        s_word_valid, s_word_ready;
  logic        s_cfg_data, s_cfg_enable, s_cfg_nreset;
  logic        s_busy, s_done;
  logic [2:0]  s_bit_count;

  logic [CW-1:0] sr, exp_img;
  logic [4:0]    s_sr;

  int checks, failures;
  int hs_cnt, en_cnt, widx, cyc_n;

  config_loader dut (
    .clock(clock), .reset(reset),
    .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .cfg_data(cfg_data),
    .cfg_enable(cfg_enable), .cfg_nreset(cfg_nreset),
    .busy(busy), .done(done), .bit_count(bit_count)
  );

  config_loader #(.CONFIG_WIDTH(5), .WORD_WIDTH(4)) dut_s (
    .clock(clock), .reset(reset),
    .start(s_start), .abort(s_abort),
    .word_data(s_word_data), .word_valid(s_word_valid),
    .word_ready(s_word_ready), .cfg_data(s_cfg_data),
    .cfg_enable(s_cfg_enable), .cfg_nreset(s_cfg_nreset),
    .busy(s_busy), .done(s_done), .bit_count(s_bit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!cfg_nreset) sr <= '0;
    else if (cfg_enable) sr <= {sr[CW-2:0], cfg_data};
  end

  always @(posedge clock) begin
    if (!s_cfg_nreset) s_sr <= '0;
    else if (s_cfg_enable) s_sr <= {s_sr[3:0], s_cfg_data};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    logic hs, en;
    hs = word_valid && word_ready;
    en = cfg_enable;
    @(posedge clock);
    #1;
    cyc_n++;
    if (hs) begin
      hs_cnt++;
      widx++;
      word_data = widx[7:0];
    end
    if (en) en_cnt++;
  endtask

  task automatic start_load();
    widx = 0;
    word_data = 8'h00;
    hs_cnt = 0;
    en_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic int img_diff();
    int d;
    d = 0;
    for (int i = 0; i < CW; i++)
      if (sr[i] !== exp_img[i]) d++;
    return d;
  endfunction

  initial begin
    int n, g, t0, bc, rdy_ok, s_hs;
    logic shs, sen, sd;
    logic [4:0] stream;
    checks = 0; failures = 0;
    hs_cnt = 0; en_cnt = 0; widx = 0; cyc_n = 0;
    start = 0; abort = 0; word_data = 0; word_valid = 0;
    s_start = 0; s_abort = 0; s_word_data = 0; s_word_valid = 0;
    for (int i = 0; i < 200; i++) exp_img[CW-1-8*i -: 8] = 8'(i);
    exp_img[1:0] = 2'b11;

    // reset
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_nreset", cfg_nreset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_ready", word_ready, 0);
    reset = 1'b0;
    cyc();
    chk("idle_nreset", cfg_nreset, 1);

    // full load, host always valid
    word_valid = 1'b1;
    start_load();
    chk("clear_nreset", cfg_nreset, 0);
    chk("clear_busy", busy, 1);
    chk("clear_ready", word_ready, 0);
    cyc();
    chk("load_ready", word_ready, 1);
    chk("load_bc0", bit_count, 0);
    n = 1;
    while (!done && n < 3000) begin cyc(); n++; end
    chk("done_latency", n, 1804);
    chk("handshakes", hs_cnt, 201);
    chk("enables", en_cnt, 1602);
    chk("bc_full", bit_count, 1602);
    chk("sr_top", sr[1601:1594], 8'h00);
    chk("sr_low", sr[1:0], 2'b11);
    chk("sr_image", img_diff(), 0);

    // extra words after done
    rdy_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (word_ready !== 1'b0) rdy_ok = 0;
      cyc();
    end
    chk("post_ready", rdy_ok, 1);
    chk("post_enables", en_cnt, 1602);
    chk("post_hs", hs_cnt, 201);
    chk("post_bc", bit_count, 1602);
    chk("post_done", done, 1);

    // second load with host stall and ignored start
    start_load();
    t0 = cyc_n;
    chk("restart_nreset", cfg_nreset, 0);
    cyc();
    chk("restart_done0", done, 0);
    chk("restart_bc0", bit_count, 0);
    g = 0;
    while (!(word_ready && hs_cnt == 3) && g < 100) begin
      cyc(); g++;
    end
    chk("stall_reach", bit_count, 24);
    word_valid = 1'b0;
    bc = en_cnt;
    rdy_ok = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (word_ready !== 1'b1) rdy_ok = 0;
    end
    chk("stall_ready", rdy_ok, 1);
    chk("stall_no_en", en_cnt - bc, 0);
    chk("stall_bc", bit_count, 24);
    word_valid = 1'b1;
    g = 0;
    while (!(cfg_enable && bit_count == 40) && g < 100) begin
      cyc(); g++;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("shift_start_busy", busy, 1);
    chk("shift_start_nreset", cfg_nreset, 1);
    g = 0;
    while (!done && g < 3000) begin cyc(); g++; end
    chk("stall_latency", cyc_n - t0, 1809);
    chk("stall_hs", hs_cnt, 201);
    chk("stall_enables", en_cnt, 1602);
    chk("stall_image", img_diff(), 0);

    // abort mid-load
    start_load();
    g = 0;
    while (bit_count != 100 && g < 3000) begin cyc(); g++; end
    chk("abort_reach", bit_count, 100);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_nreset", cfg_nreset, 1);
    chk("abort_ready", word_ready, 0);
    chk("abort_enable", cfg_enable, 0);
    cyc();
    chk("abort_idle", busy, 0);
    start_load();
    chk("reload_nreset", cfg_nreset, 0);
    cyc();
    chk("reload_nreset_hi", cfg_nreset, 1);
    chk("reload_bc0", bit_count, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // start with abort in idle
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_nreset", cfg_nreset, 1);
    cyc();
    chk("sa_busy2", busy, 0);

    // reset mid-shift
    start_load();
    g = 0;
    while (!(cfg_enable && bit_count == 50) && g < 3000) begin
      cyc(); g++;
    end
    reset = 1'b1;
    cyc();
    chk("mid_rst_nreset", cfg_nreset, 0);
    chk("mid_rst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("mid_rst_sr_zero", (|sr), 0);
    chk("mid_rst_bc", bit_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_nreset_hi", cfg_nreset, 1);
    word_valid = 1'b0;

    // small instance: 5-bit chain, 4-bit words
    s_word_data = 4'hA;
    s_word_valid = 1'b1;
    s_start = 1'b1;
    @(posedge clock);
    #1;
    s_start = 1'b0;
    n = 0; s_hs = 0; stream = '0;
    while (!s_done && n < 40) begin
      shs = s_word_valid && s_word_ready;
      sen = s_cfg_enable;
      sd  = s_cfg_data;
      @(posedge clock);
      #1;
      n++;
      if (shs) begin s_hs++; s_word_data = 4'hF; end
      if (sen) stream = {stream[3:0], sd};
    end
    chk("s_latency", n, 8);
    chk("s_stream", stream, 5'b10101);
    chk("s_sr", s_sr, 5'b10101);
    chk("s_bc", s_bit_count, 5);
    chk("s_hs", s_hs, 2);
    @(posedge clock);
    #1;
    chk("s_ready_done", s_word_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Sequencer that loads the fabric configuration chain. It accepts bitstream words from a host port with a valid/ready handshake and clears the config shift register before each load. It serializes the words MSB-first into the register's serial input, strobing its shift enable exactly CONFIG_WIDTH times, then reports completion. It sits between the host/bitstream interface and the config shift register, sharing that register's clock.

## Interface
- CONFIG_WIDTH, 1602: length of the config shift register chain in bits (≥1).
- WORD_WIDTH, 8: host word width in bits (≥1).
- clock  in  1  single clock for all state; the shift register uses the same clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load.
- abort  in  1  single-cycle request to stop any load.
- word_data  in  WORD_WIDTH  bitstream word; bit WORD_WIDTH-1 is shifted first.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  controller accepts word_data this cycle.
- cfg_data  out  1  to shift register data_in.
- cfg_enable  out  1  to shift register enable.
- cfg_nreset  out  1  to shift register nreset (active-low clear).
- busy  out  1  load in progress (CLEAR, LOAD, SHIFT).
- done  out  1  level; the last load completed with all CONFIG_WIDTH bits.
- bit_count  out  clog2(CONFIG_WIDTH+1)  bits shifted since the last CLEAR.

## Operation
- States: IDLE, CLEAR, LOAD, SHIFT, DONE. Registers: state, word_reg[WORD_WIDTH], bit_count, word_bit counter (clog2(WORD_WIDTH+1)).
- IDLE/DONE: start → CLEAR. A start during CLEAR/LOAD/SHIFT is ignored.
- CLEAR (one cycle): cfg_nreset=0, bit_count←0, done←0 → LOAD.
- LOAD: word_ready=1. word_valid&word_ready → word_reg←word_data, word_bit←0 → SHIFT.
- SHIFT: cfg_enable=1 and cfg_data=word_reg[WORD_WIDTH-1] every cycle. On each shifting edge: word_reg shifts left by 1, word_bit+1, bit_count+1.
  - If bit_count+1 == CONFIG_WIDTH → DONE, done←1. Any remaining bits of the current word are discarded.
  - Else if word_bit+1 == WORD_WIDTH → LOAD.
- Bit ordering: the first bit shifted ends at register data_out[CONFIG_WIDTH-1]; the last bit ends at data_out[0].
- abort (any state, including DONE) → IDLE next cycle, done←0. Register contents are left as they are. abort wins over a simultaneous start.
- word_ready=0 outside LOAD, so words offered in IDLE/CLEAR/SHIFT/DONE are never consumed.
- bit_count never exceeds CONFIG_WIDTH and holds its value in DONE/IDLE until the next CLEAR.
- Words needed per load: ceil(CONFIG_WIDTH/WORD_WIDTH). For the defaults this is 201, and only the top 2 bits of the last word are used.

## Timing
- Reset (synchronous): state=IDLE, done=0, bit_count=0, word_reg=0, word_bit=0.
- cfg_nreset = !(reset | state==CLEAR), decoded combinationally, so the shift register clears during controller reset too.
- Other outputs decode combinationally from registered state: word_ready=(LOAD), cfg_enable=(SHIFT), busy=(CLEAR|LOAD|SHIFT), cfg_data=word_reg MSB in SHIFT and 0 otherwise.
- start sampled at edge N: CLEAR during cycle N+1, LOAD from N+2.
- Per full word: 1 LOAD cycle + WORD_WIDTH SHIFT cycles. A stalled host extends LOAD without limit.
- Reset mid-load behaves like abort plus a clear of the register: the next cycle is IDLE and done=0.

## Test plan
- Defaults, word_valid held 1, words 0x00..0xC8, start at cycle 0 → CLEAR at cycle 1, LOAD at cycle 2, done rises after 200×9+3=1803 cycles. Exactly 201 handshakes, 1602 cfg_enable pulses, shift register bits [1601:1594]=0x00 and [1:0]=0xC8[7:6]=2'b11.
- Host stall: word_valid low for 5 cycles in LOAD → word_ready stays 1, no cfg_enable, bit_count frozen. Load resumes with no lost or duplicated bits.
- Extra words after DONE: word_valid kept high → word_ready=0, no further cfg_enable, bit_count=1602, done stays 1.
- abort at bit_count=100 → IDLE the next cycle, done=0, busy=0, cfg_nreset stays 1. A new start gives one cfg_nreset=0 cycle and bit_count=0.
- start and abort in the same cycle while in IDLE → stays IDLE. start while in SHIFT → ignored, bit sequence unchanged.
- reset asserted mid-SHIFT → cfg_nreset=0 during reset, shift register reads 0, state=IDLE. CONFIG_WIDTH=5, WORD_WIDTH=4, words 0xA,0xF → shifted stream 1,0,1,0,1, register=5'b10101.
